det_event_logger: RTL and testbench
===================================

# det_event_logger

Downstream consumer of the serial sequence detector's one-bit detect output. It timestamps every detection against a free-running bit-position counter and buffers the timestamps in a small FIFO. Software or a test harness drains the FIFO through a simple read strobe. It also keeps a saturating total-detection count and a sticky overflow flag, so no detection is silently lost.

## Interface
- `CNT_W`, 16: width of the bit-position counter, timestamps and total count.
- `DEPTH`, 4: FIFO depth in entries. Must be a power of 2 and at least 2.

- `clk` input 1: single clock, rising-edge active.
- `rst_n` input 1: reset. Synchronous, active-low, with priority over every other input.
- `det` input 1: detector output. Level signal, sampled every `clk`.
- `clr` input 1: synchronous clear of the FIFO, counters and flags. Second priority after `rst_n`.
- `rd_en` input 1: pop request.
- `rd_data` output `CNT_W`: timestamp of the popped entry. Registered.
- `rd_valid` output 1: `rd_data` is valid this cycle. One-cycle pulse.
- `empty` output 1: FIFO holds 0 entries.
- `full` output 1: FIFO holds `DEPTH` entries.
- `overflow` output 1: sticky. Set when a detection was dropped.
- `total_count` output `CNT_W`: detections seen since reset or `clr`. Saturating.

## Operation
- **Bit-position counter `pos`:**
  - `CNT_W` bits, increments on every `clk`.
  - Wraps from all-ones to 0.
  - Reads 0 in the first cycle after `rst_n` deasserts or after a `clr` cycle.
- **Detection event:** `ev = det & ~det_q`, where `det_q` is `det` registered and resets to 0.
  - Only rising edges count.
  - Holding `det` high for N cycles produces exactly one event.
- **Push:** on `ev`, the value of `pos` in that same cycle (before its increment) is written into the FIFO.
- **Pop:** `rd_en & ~empty` removes the oldest entry.
  - On the next edge, `rd_data` takes that entry and `rd_valid` is 1.
  - `rd_en` while empty is ignored: `rd_valid` is 0 and `rd_data` holds its value.
- **Full behaviour:**
  - Push with pop in the same cycle while full: both are performed, no overflow.
  - Push without pop while full: the entry is dropped and `overflow` is set.
  - Push with pop in the same cycle while empty: push only, since the pop is ignored.
- **`total_count`:**
  - Increments on every `ev`, including dropped ones.
  - Holds at all-ones (saturates).
- **`clr`:**
  - Empties the FIFO and zeroes `pos`, `total_count`, `overflow`, `rd_valid` and `det_q`.
  - An `ev` or `rd_en` in the same cycle is discarded.
- **Reset values:** `rd_data` = 0, `rd_valid` = 0, `empty` = 1, `full` = 0, `overflow` = 0, `total_count` = 0.
- **Reset mid-operation:** all contents are lost and there is no partial pop. Identical to `clr`.

## Timing
- Push latency is 1 cycle. If `ev` occurs in cycle n, `empty` falls after edge n+1, i.e. it is visible in cycle n+1.
- Pop latency is 1 cycle. `rd_en` in cycle n gives `rd_data`/`rd_valid` in cycle n+1.
- `empty` and `full` are registered state decoded from the pointers, and reflect the pushes and pops of the previous edge.
- Back-to-back pops are allowed every cycle.
- The minimum spacing between detections is 2 cycles; the detector never produces faster.

## Structure
- Shared package `det_pkg`: `CNT_W` default, and a `PTR_W = $clog2(DEPTH)` helper function.
- Sub-module `sync_fifo`, parameterised on `WIDTH` and `DEPTH`:
  - Write/read pointers of `PTR_W+1` bits, so full and empty are distinguished by the MSB.
  - Registered read data.
  - Synchronous active-low reset plus a `clr` input.
- The top level holds the event edge detect, `pos`, `total_count`, the `overflow` flag and the FIFO instance.

## Test plan
- **Reset:** `rst_n` low for 2 cycles, with `det` = 1 and `rd_en` = 1 during reset.
  - After release: `empty` = 1, `full` = 0, `overflow` = 0, `total_count` = 0, `rd_valid` = 0, `pos` = 0.
- **Two pulses:** single-cycle `det` pulses at pos 5 and pos 8, then two pops.
  - `rd_data` returns 5 then 8, each with `rd_valid` = 1.
  - `total_count` = 2 and `empty` = 1 afterwards.
- **Held `det`:** `det` held high for pos 3–6.
  - Exactly one entry, 3.
  - `total_count` = 1.
- **Overflow** (`DEPTH` = 4): 5 pulses at pos 2, 4, 6, 8, 10 with no reads.
  - `full` = 1 after the 4th pulse.
  - `overflow` = 1 after the 5th.
  - `total_count` = 5.
  - Pops return 2, 4, 6, 8, then `empty` = 1.
- **Full with simultaneous push and pop:** FIFO full with 2, 4, 6, 8; pulse at pos 12 with `rd_en` in the same cycle.
  - `overflow` stays 0.
  - Pops return 2, 4, 6, 8, 12.
- **Clear and reset priority:** `clr` in the same cycle as `det` rising, with 3 entries queued.
  - All outputs return to reset values.
  - The next pulse 4 cycles later logs timestamp 4.
  - Repeat with `rst_n` mid-pop: same result.
- **Wrap-around** (`CNT_W` = 4): pulse at pos 15, then at pos 1 after the wrap.
  - Pops return 15 then 1.

Source files
------------

// File: rtl/det_pkg.sv
// Shared constants and helpers for the detection event logger.
package det_pkg;

  localparam int unsigned DefaultCntW = 16;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/det_event_logger_sync_fifo.sv
// Synchronous FIFO with registered read data. Pointers carry one extra bit so
// full and empty are told apart by the MSB.
module sync_fifo
  import det_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = ptr_w(DEPTH);

  logic [PtrW:0]    wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                 (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);

  // A write into a full FIFO is only accepted when a pop frees the slot
  // in the same cycle; the read below sees the old slot contents.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_rd) begin
        rd_data <= mem_q[rptr_q[PtrW-1:0]];
        rptr_q  <= rptr_q + (PtrW+1)'(1);
      end
      if (do_wr) begin
        wptr_q <= wptr_q + (PtrW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clr && do_wr) begin
      mem_q[wptr_q[PtrW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/det_event_logger.sv
// Timestamps rising edges of the detector output against a free-running
// bit-position counter and queues them for readout.
module det_event_logger
  import det_pkg::*;
#(
  parameter int unsigned CNT_W = DefaultCntW,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             det,
  input  logic             clr,
  input  logic             rd_en,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic [CNT_W-1:0] total_count
);

  logic             det_q;
  logic             ovf_q;
  logic [CNT_W-1:0] pos_q;
  logic [CNT_W-1:0] total_q;
  logic             ev;
  logic             drop;

  assign ev   = det & ~det_q;
  // A full FIFO can only be non-empty, so any rd_en there is a real pop.
  assign drop = ev & full & ~rd_en;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      det_q   <= 1'b0;
      ovf_q   <= 1'b0;
      pos_q   <= '0;
      total_q <= '0;
    end else begin
      det_q <= det;
      pos_q <= pos_q + CNT_W'(1);
      if (ev && (total_q != '1)) begin
        total_q <= total_q + CNT_W'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign overflow    = ovf_q;
  assign total_count = total_q;

  sync_fifo #(
    .WIDTH(CNT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (ev),
    .wr_data (pos_q),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .empty   (empty),
    .full    (full)
  );

endmodule

// File: tb/tb_det_event_logger.sv
// Scoreboard bench: stimulus pushes hand-computed timestamps, monitors pop
// and compare whenever rd_valid is seen.
module tb_det_event_logger;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        det = 1'b0;
  logic        rd_en = 1'b0;
  logic        det_s = 1'b0;
  logic        rd_en_s = 1'b0;

  logic [15:0] rd_data;
  logic        rd_valid, empty, full, overflow;
  logic [15:0] total_count;
  logic [3:0]  rd_data_s;
  logic        rd_valid_s, empty_s, full_s, overflow_s;
  logic [3:0]  total_count_s;

  int n_checks = 0;
  int n_errs   = 0;
  int tpos     = 0;
  int sb   [$];
  int sb_s [$];

  always #5 clk = ~clk;

  det_event_logger #(.CNT_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .det(det), .clr(clr), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .overflow(overflow), .total_count(total_count)
  );

  det_event_logger #(.CNT_W(4), .DEPTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .det(det_s), .clr(clr), .rd_en(rd_en_s),
    .rd_data(rd_data_s), .rd_valid(rd_valid_s), .empty(empty_s), .full(full_s),
    .overflow(overflow_s), .total_count(total_count_s)
  );

  // Monitors
  always @(negedge clk) begin
    if (rd_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errs++;
        $display("FAIL rd_data: unexpected rd_valid with data %0d, none required", rd_data);
      end else begin
        int e;
        e = sb.pop_front();
        if (int'(rd_data) != e) begin
          n_errs++;
          $display("FAIL rd_data: got %0d required %0d", rd_data, e);
        end
      end
    end
    if (rd_valid_s) begin
      n_checks++;
      if (sb_s.size() == 0) begin
        n_errs++;
        $display("FAIL rd_data_s: unexpected rd_valid with data %0d, none required", rd_data_s);
      end else begin
        int e;
        e = sb_s.pop_front();
        if (int'(rd_data_s) != e) begin
          n_errs++;
          $display("FAIL rd_data_s: got %0d required %0d", rd_data_s, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // One clock; tpos tracks the DUT bit-position counter.
  task automatic step();
    @(posedge clk);
    if (!rst_n || clr) tpos = 0;
    else tpos++;
    #1;
  endtask

  task automatic goto_pos(input int p);
    for (int i = 0; i < 200 && tpos != p; i++) step();
    if (tpos != p) begin
      n_errs++;
      $display("FAIL goto_pos: reached %0d required %0d", tpos, p);
    end
  endtask

  task automatic pulse(input int p, input bit expect_push);
    goto_pos(p);
    det = 1'b1;
    step();
    det = 1'b0;
    if (expect_push) sb.push_back(p);
  endtask

  task automatic pulse_s(input int p, input int ts, input bit expect_push);
    goto_pos(p);
    det_s = 1'b1;
    step();
    det_s = 1'b0;
    if (expect_push) sb_s.push_back(ts);
  endtask

  task automatic pop(input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic drain_check(input string name);
    step();
    step();
    chk(name, sb.size() + sb_s.size(), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " empty"}, int'(empty), 1);
    chk({tag, " full"}, int'(full), 0);
    chk({tag, " overflow"}, int'(overflow), 0);
    chk({tag, " total"}, int'(total_count), 0);
    chk({tag, " rd_valid"}, int'(rd_valid), 0);
    chk({tag, " rd_data"}, int'(rd_data), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with det and rd_en asserted
    rst_n = 1'b0; det = 1'b1; rd_en = 1'b1;
    step();
    step();
    rst_n = 1'b1; det = 1'b0; rd_en = 1'b0;
    chk_reset_state("reset");

    // Two pulses; timestamps also prove pos starts at 0
    pulse(5, 1'b1);
    pulse(8, 1'b1);
    chk("two empty_before_pop", int'(empty), 0);
    pop(2);
    drain_check("two drained");
    chk("two total", int'(total_count), 2);
    chk("two empty", int'(empty), 1);

    // Held det yields one event; pop while empty is ignored
    do_clr();
    goto_pos(3);
    det = 1'b1;
    for (int i = 0; i < 4; i++) step();
    det = 1'b0;
    sb.push_back(3);
    pop(1);
    drain_check("held drained");
    chk("held total", int'(total_count), 1);
    pop(1);
    step();
    chk("empty_pop rd_valid", int'(rd_valid), 0);
    chk("empty_pop rd_data_hold", int'(rd_data), 3);

    // Overflow
    do_clr();
    pulse(2, 1'b1);
    pulse(4, 1'b1);
    pulse(6, 1'b1);
    chk("ovf full_after3", int'(full), 0);
    pulse(8, 1'b1);
    chk("ovf full_after4", int'(full), 1);
    chk("ovf overflow_after4", int'(overflow), 0);
    pulse(10, 1'b0);
    chk("ovf overflow_after5", int'(overflow), 1);
    chk("ovf total", int'(total_count), 5);
    pop(4);
    drain_check("ovf drained");
    chk("ovf empty", int'(empty), 1);
    chk("ovf sticky", int'(overflow), 1);

    // Full with simultaneous push and pop
    do_clr();
    pulse(2, 1'b1);
    pulse(4, 1'b1);
    pulse(6, 1'b1);
    pulse(8, 1'b1);
    goto_pos(12);
    det = 1'b1; rd_en = 1'b1;
    step();
    det = 1'b0; rd_en = 1'b0;
    sb.push_back(12);
    chk("simul overflow", int'(overflow), 0);
    chk("simul full", int'(full), 1);
    pop(4);
    drain_check("simul drained");
    chk("simul empty", int'(empty), 1);

    // clr coincident with a det rising edge, 3 entries queued
    do_clr();
    pulse(2, 1'b0);
    pulse(4, 1'b0);
    pulse(6, 1'b0);
    goto_pos(8);
    det = 1'b1; clr = 1'b1;
    step();
    det = 1'b0; clr = 1'b0;
    chk_reset_state("clr");
    pulse(4, 1'b1);
    pop(1);
    drain_check("clr drained");
    chk("clr total", int'(total_count), 1);

    // Reset during a pop
    do_clr();
    pulse(6, 1'b0);
    pulse(8, 1'b0);
    pulse(10, 1'b0);
    rd_en = 1'b1; rst_n = 1'b0;
    step();
    rd_en = 1'b0; rst_n = 1'b1;
    chk_reset_state("rst");
    pulse(4, 1'b1);
    pop(1);
    drain_check("rst drained");

    // Wrap-around on the 4-bit instance
    do_clr();
    pulse_s(15, 15, 1'b1);
    pulse_s(17, 1, 1'b1);
    rd_en_s = 1'b1;
    step();
    step();
    rd_en_s = 1'b0;
    drain_check("wrap drained");
    chk("wrap total", int'(total_count_s), 2);

    // Saturation of total_count on the 4-bit instance
    do_clr();
    for (int k = 0; k < 17; k++) pulse_s(2 * k + 1, 0, 1'b0);
    chk("sat total", int'(total_count_s), 15);
    chk("sat overflow", int'(overflow_s), 1);
    do_clr();
    chk("sat clr total", int'(total_count_s), 0);
    chk("sat clr empty", int'(empty_s), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
